pipeline_muldiv: RTL and testbench
==================================

# pipeline_muldiv

Parametrised multi-cycle multiply/divide unit that owns the HI/LO architectural registers for the execute stage. It accepts one operation per handshake from the ALU stage. Supported operations are signed and unsigned multiply, multiply-accumulate and multiply-subtract, signed and unsigned divide, and direct HI/LO writes. It replaces the fixed single-cycle late-ALU multiply path with a pipelined multiplier of configurable latency and an iterative divider with configurable radix. While an operation is in flight it raises `busy`, so the ALU stage can stall `mfhi`/`mflo`.

## Interface
- `XLEN`, 32: operand width; HI and LO are each `XLEN` bits.
- `MUL_LATENCY`, 2: cycles from accept to HI/LO update for multiply-class ops; legal range is 1..4.
- `DIV_UNROLL`, 1: quotient bits resolved per divider cycle; legal values are 1, 2, 4; must divide `XLEN`.
- `clk`  in  1  single clock; all state is rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  operation request from the ALU stage.
- `req_ready`  out  1  equals `!busy && !flush`.
- `req_op`  in  4  operation code (encodings in package).
- `req_a`, `req_b`  in  `XLEN`  rs / rt operand values.
- `flush`  in  1  abort any in-flight op (exception or branch squash).
- `hi`, `lo`  out  `XLEN`  architectural HI/LO, driven directly from registers.
- `busy`  out  1  a multiply-class or divide op is in flight.
- `done`  out  1  one-cycle pulse on the edge HI/LO take a mul/div result.
- `op_err`  out  1  one-cycle pulse when an unknown `req_op` is accepted.

## Operation
- Accept: `req_valid && req_ready` at a rising edge. Operands and op are latched.
- Op codes:
  - 1 MULT, 2 MULTU: {HI,LO} = a*b, signed / unsigned.
  - 3 DIV, 4 DIVU: LO = quotient, HI = remainder.
  - 5 MTHI: HI = a. 6 MTLO: LO = a.
  - 7 MADD, 8 MADDU: {HI,LO} += a*b.
  - 9 MSUB, 10 MSUBU: {HI,LO} -= a*b.
  - Accumulate ops use the HI/LO value present at accept; wrap modulo 2^(2·XLEN).
  - 0 and 11–15: no state change; `op_err` pulses on the next cycle.
- MTHI/MTLO write on the accept edge itself; `busy` is never asserted for them.
- State machine, states IDLE, MUL, DIV, DIV_FIX:
  - IDLE → MUL on an accepted multiply-class op; counter loaded with `MUL_LATENCY-1`.
  - IDLE → DIV on an accepted divide op; counter loaded with `XLEN/DIV_UNROLL-1`.
  - MUL → IDLE when the counter is 0: HI/LO written, `done` pulses.
  - DIV performs restoring division on magnitudes, `DIV_UNROLL` bits per cycle. DIV → DIV_FIX when the counter is 0.
  - DIV_FIX applies signs for DIV: quotient is negated if the operand signs differ; remainder takes the dividend's sign. It then writes HI/LO, pulses `done` and returns to IDLE.
- Divide by zero: LO = all-ones, HI = dividend. Takes normal latency; no exception.
- Signed overflow (DIV of −2^(XLEN−1) by −1): LO = −2^(XLEN−1), HI = 0.
- `flush` from any state: return to IDLE next edge; HI/LO unchanged; no `done`.
  - `flush` with `req_valid` in the same cycle: the request is dropped.
  - `flush` in IDLE: no effect.

## Timing
- Reset (async assert, sync-safe deassert): `hi`=0, `lo`=0, `busy`=0, `done`=0, `op_err`=0, state IDLE. `req_ready` is therefore 1 once reset releases.
- `busy` rises the cycle after accept and falls on the edge that writes HI/LO.
  - Multiply-class ops: `busy` high for exactly `MUL_LATENCY` cycles.
  - Divide ops: `busy` high for exactly `XLEN/DIV_UNROLL + 1` cycles (33 at defaults).
- New HI/LO is visible in the first cycle with `busy`=0. `done` is high in that same cycle.
- Back-to-back ops: the next accept is allowed in the cycle `busy` falls (throughput 1 op per latency + 0 bubbles).
- Reset asserted mid-operation: immediate return to the reset values; the partial result is discarded.

## Structure
- Package `pipeline_muldiv_pkg` holds:
  - the 4-bit op encodings;
  - the state enum;
  - a helper constant `DIV_CYCLES = XLEN/DIV_UNROLL`.
- Sub-module `pipeline_muldiv_div_iter` is one combinational restoring-division step of `DIV_UNROLL` bits. It takes remainder, dividend-shift and divisor, and returns the updated remainder and quotient bits.
- The top level holds:
  - the FSM;
  - the counter;
  - the multiplier shift-register pipeline of depth `MUL_LATENCY`, built from a plain `*` followed by retiming registers;
  - the HI/LO registers.

## Test plan
- MULT a=0xFFFFFFFE (−2), b=3 → after 2 busy cycles HI=0xFFFFFFFF, LO=0xFFFFFFFA, `done` pulses once. MULTU with the same operands → HI=0x2, LO=0xFFFFFFFA.
- DIV a=−7 (0xFFFFFFF9), b=2 → `busy` high 33 cycles, then LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). DIVU a=7, b=0 → LO=0xFFFFFFFF, HI=7.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0. Repeat with `DIV_UNROLL`=4 → `busy` high for 9 cycles, same result.
- MTHI 0x12345678, then MTLO 1 on consecutive cycles → HI/LO visible one cycle after each accept, `busy` stays 0. MADDU a=0xFFFFFFFF, b=2 → HI=0x12345679, LO=0xFFFFFFFF.
- Start DIV; assert `flush` on busy cycle 10 together with `req_valid` → next cycle `busy`=0 and HI/LO unchanged. The flushed request is not accepted and `done` never pulses.
- Drive `rst` low mid-MULT → `hi`=`lo`=0 and `busy`=0 immediately. Separately, accept `req_op`=12 → `op_err` pulses once and HI/LO are unchanged.

Source files
------------

// File: rtl/pipeline_muldiv_pkg.sv
// Shared op encodings, FSM state type and sizing helpers for the multiply/divide unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipeline_muldiv_pkg;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MUL     = 2'd1,
        ST_DIV     = 2'd2,
        ST_DIV_FIX = 2'd3
    } state_e;

    // How a finished product is folded into {HI,LO}
    typedef enum logic [1:0] {
        ACC_NONE = 2'd0,
        ACC_ADD  = 2'd1,
        ACC_SUB  = 2'd2
    } acc_e;

    // Divider iteration count at the default geometry; instances with other
    // parameters size themselves through div_cycles().
    localparam int DEF_XLEN       = 32;
    localparam int DEF_DIV_UNROLL = 1;
    localparam int DIV_CYCLES     = DEF_XLEN / DEF_DIV_UNROLL;

    function automatic int div_cycles(input int xlen, input int unroll);
        return xlen / unroll;
    endfunction

    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) ||
               (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // Ops whose operands are interpreted as two's complement
    function automatic logic is_signed_op(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

    function automatic logic is_known_op(input logic [3:0] op);
        return (op != OP_NOP) && (op <= OP_MSUBU);
    endfunction

    function automatic acc_e acc_mode(input logic [3:0] op);
        if ((op == OP_MADD) || (op == OP_MADDU)) return ACC_ADD;
        if ((op == OP_MSUB) || (op == OP_MSUBU)) return ACC_SUB;
        return ACC_NONE;
    endfunction

endpackage

// File: rtl/pipeline_muldiv_div_iter.sv
// One combinational restoring-division step resolving UNROLL quotient bits.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller registers the outputs each divider cycle.
module pipeline_muldiv_div_iter #(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic [XLEN-1:0]   rem,
    input  logic [UNROLL-1:0] dvd_top,
    input  logic [XLEN-1:0]   dsr,
    output logic [XLEN-1:0]   rem_next,
    output logic [UNROLL-1:0] quo_bits
);

    logic [XLEN:0] part;
    logic [XLEN:0] trial;

    // Shift in dividend bits MSB first; subtract divisor whenever it fits.
    // The partial remainder stays below the divisor, so one extra bit of
    // headroom is enough for the trial value.
    always_comb begin
        part     = {1'b0, rem};
        trial    = '0;
        quo_bits = '0;
        for (int i = 0; i < UNROLL; i++) begin
            trial = {part[XLEN-1:0], dvd_top[UNROLL-1-i]};
            if (trial >= {1'b0, dsr}) begin
                part                 = trial - {1'b0, dsr};
                quo_bits[UNROLL-1-i] = 1'b1;
            end else begin
                part = trial;
            end
        end
        rem_next = part[XLEN-1:0];
    end

endmodule

// File: rtl/pipeline_muldiv.sv
// Multiply/divide unit owning HI/LO: retimed multiplier plus iterative restoring divider.
// Latency: MUL_LATENCY cycles for multiply-class, XLEN/DIV_UNROLL+1 for divide, MTHI/MTLO on the accept edge.
// Backpressure: req_ready = !busy && !flush; one op in flight, no queueing.
module pipeline_muldiv
    import pipeline_muldiv_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int MUL_LATENCY = 2,
    parameter int DIV_UNROLL  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [3:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic            flush,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            busy,
    output logic            done,
    output logic            op_err
);

    localparam int DIV_CYC = div_cycles(XLEN, DIV_UNROLL);
    localparam int CNT_W   = $clog2(DIV_CYC) + 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LATENCY - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYC - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   hi_q, lo_q;
    logic              done_q, op_err_q;
    acc_e              acc_q;

    logic              accept, acc_mul, acc_div;
    logic              mul_wr, div_wr;

    logic [2*XLEN-1:0] ext_a, ext_b, prod, mul_res;
    logic [2*XLEN-1:0] mul_pipe [MUL_LATENCY];

    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN-1:0]   rem_q, dvd_q, dsr_q;
    logic [XLEN-1:0]   rem_step, quo_fix, rem_fix;
    logic [DIV_UNROLL-1:0] quo_step;
    logic              neg_quo_q, neg_rem_q, dzero_q;

    assign busy      = (state_q != ST_IDLE);
    assign req_ready = !busy && !flush;
    assign accept    = req_valid && req_ready;
    assign acc_mul   = accept && is_mul_op(req_op);
    assign acc_div   = accept && is_div_op(req_op);

    assign hi     = hi_q;
    assign lo     = lo_q;
    assign done   = done_q;
    assign op_err = op_err_q;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Next state and HI/LO write strobes; flush wins over every transition
    always_comb begin
        state_d = state_q;
        mul_wr  = 1'b0;
        div_wr  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (acc_mul)      state_d = ST_MUL;
                else if (acc_div) state_d = ST_DIV;
            end
            ST_MUL: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    mul_wr  = 1'b1;
                end
            end
            ST_DIV: begin
                if (cnt_q == '0) state_d = ST_DIV_FIX;
            end
            ST_DIV_FIX: begin
                state_d = ST_IDLE;
                div_wr  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d = ST_IDLE;
            mul_wr  = 1'b0;
            div_wr  = 1'b0;
        end
    end

    // Cycle counter: loaded on accept, counts down while an op is in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (acc_mul) begin
            cnt_q <= MUL_LOAD;
        end else if (acc_div) begin
            cnt_q <= DIV_LOAD;
        end else if (((state_q == ST_MUL) || (state_q == ST_DIV)) && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Full-width product of the request operands, sign- or zero-extended
    always_comb begin
        if (is_signed_op(req_op)) begin
            ext_a = {{XLEN{req_a[XLEN-1]}}, req_a};
            ext_b = {{XLEN{req_b[XLEN-1]}}, req_b};
        end else begin
            ext_a = {{XLEN{1'b0}}, req_a};
            ext_b = {{XLEN{1'b0}}, req_b};
        end
        prod = ext_a * ext_b;
    end

    // Product captured at accept, then carried through retiming stages
    always_ff @(posedge clk) begin
        if (acc_mul) mul_pipe[0] <= prod;
        for (int i = 1; i < MUL_LATENCY; i++) mul_pipe[i] <= mul_pipe[i-1];
    end

    // HI/LO cannot change while a multiply is in flight, so the live
    // registers are the accumulate base captured at accept.
    always_comb begin
        unique case (acc_q)
            ACC_ADD: mul_res = {hi_q, lo_q} + mul_pipe[MUL_LATENCY-1];
            ACC_SUB: mul_res = {hi_q, lo_q} - mul_pipe[MUL_LATENCY-1];
            default: mul_res = mul_pipe[MUL_LATENCY-1];
        endcase
    end

    // Operand magnitudes for the divider
    always_comb begin
        a_neg = is_signed_op(req_op) && req_a[XLEN-1];
        b_neg = is_signed_op(req_op) && req_b[XLEN-1];
        a_mag = a_neg ? -req_a : req_a;
        b_mag = b_neg ? -req_b : req_b;
    end

    pipeline_muldiv_div_iter #(
        .XLEN   (XLEN),
        .UNROLL (DIV_UNROLL)
    ) u_div_iter (
        .rem      (rem_q),
        .dvd_top  (dvd_q[XLEN-1 -: DIV_UNROLL]),
        .dsr      (dsr_q),
        .rem_next (rem_step),
        .quo_bits (quo_step)
    );

    // Divider datapath: dvd_q shifts the dividend out and the quotient in
    always_ff @(posedge clk) begin
        if (acc_div) begin
            rem_q     <= '0;
            dvd_q     <= a_mag;
            dsr_q     <= b_mag;
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            dzero_q   <= (req_b == '0);
        end else if (state_q == ST_DIV) begin
            rem_q <= rem_step;
            dvd_q <= {dvd_q[XLEN-DIV_UNROLL-1:0], quo_step};
        end
    end

    // Sign fix-up. A zero divisor leaves the remainder equal to the dividend
    // magnitude, so the dividend-sign rule already yields HI = dividend;
    // only the quotient needs forcing to all-ones.
    always_comb begin
        rem_fix = neg_rem_q ? -rem_q : rem_q;
        if (dzero_q)        quo_fix = '1;
        else if (neg_quo_q) quo_fix = -dvd_q;
        else                quo_fix = dvd_q;
    end

    // Architectural HI/LO; MTHI/MTLO only accept while idle so never collide
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (mul_wr) begin
            {hi_q, lo_q} <= mul_res;
        end else if (div_wr) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
        end else if (accept && (req_op == OP_MTHI)) begin
            hi_q <= req_a;
        end else if (accept && (req_op == OP_MTLO)) begin
            lo_q <= req_a;
        end
    end

    // Completion / error pulses and the accumulate mode of the pending multiply
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q   <= 1'b0;
            op_err_q <= 1'b0;
            acc_q    <= ACC_NONE;
        end else begin
            done_q   <= mul_wr || div_wr;
            op_err_q <= accept && !is_known_op(req_op);
            if (acc_mul) acc_q <= acc_mode(req_op);
        end
    end

endmodule

// File: tb/tb_pipeline_muldiv.sv
// Self-checking bench: two instances (default geometry and MUL_LATENCY=3/DIV_UNROLL=4).
// Latency: checks busy length per instance against the op class.
// Backpressure: requests issued only when both instances are idle, except in the flush sequence.
module tb_pipeline_muldiv;

    localparam logic [3:0] T_MULT = 4'd1, T_MULTU = 4'd2, T_DIV = 4'd3, T_DIVU = 4'd4;
    localparam logic [3:0] T_MTHI = 4'd5, T_MTLO = 4'd6, T_MADD = 4'd7, T_MADDU = 4'd8;
    localparam logic [3:0] T_MSUB = 4'd9, T_MSUBU = 4'd10;
    localparam int LAT[2] = '{2, 3};
    localparam int UNR[2] = '{1, 4};

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, flush, req_ready, busy, done, op_err;
    logic [3:0]  req_op;
    logic [31:0] req_a, req_b;
    logic [31:0] hi[2], lo[2];

    int          checks = 0;
    int          passes = 0;
    logic [63:0] m_hilo = '0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    always #5 clk = ~clk;

    pipeline_muldiv #(.XLEN(32), .MUL_LATENCY(2), .DIV_UNROLL(1)) u_dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .flush(flush[0]),
        .hi(hi[0]), .lo(lo[0]), .busy(busy[0]), .done(done[0]), .op_err(op_err[0])
    );

    pipeline_muldiv #(.XLEN(32), .MUL_LATENCY(3), .DIV_UNROLL(4)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .flush(flush[1]),
        .hi(hi[1]), .lo(lo[1]), .busy(busy[1]), .done(done[1]), .op_err(op_err[1])
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic bit t_is_mul(input logic [3:0] op);
        return op == T_MULT || op == T_MULTU || op == T_MADD || op == T_MADDU ||
               op == T_MSUB || op == T_MSUBU;
    endfunction

    function automatic int exp_busy(input logic [3:0] op, input int d);
        if (t_is_mul(op)) return LAT[d];
        if (op == T_DIV || op == T_DIVU) return 32 / UNR[d] + 1;
        return 0;
    endfunction

    // Architectural result of one op on {HI,LO}, straight from the ISA rules
    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] cur);
        longint      sa, sb, sp;
        logic [63:0] up;
        int          q, r;
        sa = $signed(a);
        sb = $signed(b);
        sp = sa * sb;
        up = {32'b0, a} * {32'b0, b};
        case (op)
            T_MULT:  return sp;
            T_MULTU: return up;
            T_MADD:  return cur + sp;
            T_MADDU: return cur + up;
            T_MSUB:  return cur - sp;
            T_MSUBU: return cur - up;
            T_DIV: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, a};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            T_DIVU: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            T_MTHI:  return {a, cur[31:0]};
            T_MTLO:  return {cur[63:32], a};
            default: return cur;
        endcase
    endfunction

    // Issue one op to both instances (called at a negedge with both idle) and
    // check each at its first non-busy cycle.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input string tag);
        int          nb[2]  = '{0, 0};
        int          bad[2] = '{0, 0};
        bit          fin[2] = '{0, 0};
        logic [31:0] h[2], l[2];
        logic        dn[2], er[2];
        req_op = op; req_a = a; req_b = b; req_valid = 2'b11;
        @(posedge clk);
        #1 req_valid = 2'b00;
        for (int k = 0; k < 100 && !(fin[0] && fin[1]); k++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (!fin[d]) begin
                    if (busy[d]) begin
                        nb[d]++;
                        if (done[d] !== 1'b0) bad[d]++;
                    end else begin
                        fin[d] = 1'b1;
                        h[d] = hi[d]; l[d] = lo[d]; dn[d] = done[d]; er[d] = op_err[d];
                    end
                end
            end
        end
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s d%0d finished", tag, d), 64'(fin[d]), 64'd1);
            chk($sformatf("%s d%0d hi", tag, d), 64'(h[d]), 64'(exp[63:32]));
            chk($sformatf("%s d%0d lo", tag, d), 64'(l[d]), 64'(exp[31:0]));
            chk($sformatf("%s d%0d busy_cycles", tag, d), 64'(nb[d]), 64'(exp_busy(op, d)));
            chk($sformatf("%s d%0d done", tag, d), 64'(dn[d]), 64'(exp_busy(op, d) > 0));
            chk($sformatf("%s d%0d early_done", tag, d), 64'(bad[d]), 64'd0);
            chk($sformatf("%s d%0d op_err", tag, d), 64'(er[d]),
                64'(op == 4'd0 || op > T_MSUBU));
        end
    endtask

    initial begin
        vec_t        tbl[17];
        int          dn_cnt[2];
        logic [3:0]  op;
        logic [31:0] a, b;
        logic [63:0] exp;

        tbl[0]  = '{T_MULT,    32'hFFFF_FFFE, 32'd3,         64'hFFFF_FFFF_FFFF_FFFA};
        tbl[1]  = '{T_MULTU,   32'hFFFF_FFFE, 32'd3,         64'h0000_0002_FFFF_FFFA};
        tbl[2]  = '{T_DIV,     32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD};
        tbl[3]  = '{T_DIVU,    32'd7,         32'd0,         64'h0000_0007_FFFF_FFFF};
        tbl[4]  = '{T_DIV,     32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000};
        tbl[5]  = '{T_MTHI,    32'h1234_5678, 32'd0,         64'h1234_5678_8000_0000};
        tbl[6]  = '{T_MTLO,    32'd1,         32'd0,         64'h1234_5678_0000_0001};
        tbl[7]  = '{T_MADDU,   32'hFFFF_FFFF, 32'd2,         64'h1234_5679_FFFF_FFFF};
        tbl[8]  = '{T_MSUB,    32'd3,         32'd5,         64'h1234_5679_FFFF_FFF0};
        tbl[9]  = '{4'd12,     32'hAAAA_AAAA, 32'd1,         64'h1234_5679_FFFF_FFF0};
        tbl[10] = '{T_DIV,     32'hFFFF_FFF9, 32'd0,         64'hFFFF_FFF9_FFFF_FFFF};
        tbl[11] = '{T_MULT,    32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        tbl[12] = '{T_DIV,     32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD};
        tbl[13] = '{T_MADD,    32'hFFFF_FFFF, 32'd3,         64'h0000_0001_FFFF_FFFA};
        tbl[14] = '{T_MSUBU,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0003_FFFF_FFF9};
        tbl[15] = '{4'd0,      32'h5555_5555, 32'd9,         64'h0000_0003_FFFF_FFF9};
        tbl[16] = '{T_DIVU,    32'hFFFF_FFF9, 32'd2,         64'h0000_0001_7FFF_FFFC};

        req_valid = '0; flush = '0; req_op = '0; req_a = '0; req_b = '0;
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset d%0d hi", d), 64'(hi[d]), 64'd0);
            chk($sformatf("reset d%0d lo", d), 64'(lo[d]), 64'd0);
            chk($sformatf("reset d%0d busy", d), 64'(busy[d]), 64'd0);
            chk($sformatf("reset d%0d done", d), 64'(done[d]), 64'd0);
            chk($sformatf("reset d%0d op_err", d), 64'(op_err[d]), 64'd0);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("post-reset req_ready", 64'(req_ready), 64'd3);

        // Directed vectors, HI/LO carried from row to row
        for (int i = 0; i < 17; i++) begin
            do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, $sformatf("vec%0d", i));
            m_hilo = tbl[i].exp;
        end

        // Flush a divide mid-flight together with a competing MTHI request
        dn_cnt = '{0, 0};
        req_op = T_DIV; req_a = 32'd100; req_b = 32'd7; req_valid = 2'b11;
        @(posedge clk);
        #1 req_valid = 2'b00;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) if (done[d] !== 1'b0) dn_cnt[d]++;
            if (k == 6)  chk("flush d1 busy after", 64'(busy[1]), 64'd0);
            if (k == 11) chk("flush d0 busy after", 64'(busy[0]), 64'd0);
            if (k == 5 || k == 10) begin
                int d;
                d = (k == 5) ? 1 : 0;
                chk($sformatf("flush d%0d busy before", d), 64'(busy[d]), 64'd1);
                req_op = T_MTHI; req_a = 32'hDEAD_BEEF;
                req_valid[d] = 1'b1; flush[d] = 1'b1;
                #1 chk($sformatf("flush d%0d req_ready", d), 64'(req_ready[d]), 64'd0);
                @(posedge clk);
                #1 req_valid = 2'b00; flush = 2'b00;
            end
        end
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("flush d%0d done pulses", d), 64'(dn_cnt[d]), 64'd0);
            chk($sformatf("flush d%0d hilo", d), {hi[d], lo[d]}, m_hilo);
            chk($sformatf("flush d%0d idle", d), 64'(busy[d]), 64'd0);
        end

        // Reset asserted in the middle of a multiply
        req_op = T_MULT; req_a = 32'd5; req_b = 32'd7; req_valid = 2'b11;
        @(posedge clk);
        #1 req_valid = 2'b00;
        @(negedge clk);
        chk("midreset busy before", 64'(busy), 64'd3);
        #2 rst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("midreset d%0d hi", d), 64'(hi[d]), 64'd0);
            chk($sformatf("midreset d%0d lo", d), 64'(lo[d]), 64'd0);
            chk($sformatf("midreset d%0d busy", d), 64'(busy[d]), 64'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        m_hilo = '0;
        @(negedge clk);
        chk("midreset done after release", 64'(done), 64'd0);

        // Random ops against the reference model, issued back to back
        for (int n = 0; n < 150; n++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 9));
                default: ;
            endcase
            exp = model(op, a, b, m_hilo);
            do_op(op, a, b, exp, $sformatf("rnd%0d op%0d", n, op));
            m_hilo = exp;
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
